// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard controller.
//   hazard_state_t : sequencer states (RUN, MEM_WAIT, TRAP)
//   NOP_INSTR      : bubble value the pipeline registers load when flushed
//   REG_ZERO       : index of the hardwired-zero register
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TRAP     = 2'd2
    } hazard_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam int          REG_ZERO  = 0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard comparator (purely combinational).
// Flags a decode-stage instruction that reads the destination of a load
// currently in EX. Writes to r0 never create a dependency.
//   id_rs1, id_rs2           : decode source registers
//   id_uses_rs1, id_uses_rs2 : decode instruction actually reads that source
//   ex_rd, ex_mem_read       : EX destination and "is a load"
//   load_use                 : one-cycle stall/bubble required
module load_use_detect
    import pipeline_pkg::*;
#(
    parameter int REG_BITS = 3
) (
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic [REG_BITS-1:0] ex_rd,
    input  logic                ex_mem_read,
    output logic                load_use
);

    logic rd_nonzero;
    logic hit_rs1;
    logic hit_rs2;

    assign rd_nonzero = (ex_rd != REG_BITS'(REG_ZERO));
    assign hit_rs1    = id_uses_rs1 && (id_rs1 == ex_rd);
    assign hit_rs2    = id_uses_rs2 && (id_rs2 == ex_rd);
    assign load_use   = ex_mem_read && rd_nonzero && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage 16-bit pipeline.
// Drives hold/flush of the IF/ID, ID/EX, EX/MEM, MEM/WB registers and the
// PC write enable, resolving load-use hazards, taken-branch redirects and
// data-memory waits (with a timeout trap). Also counts stalled cycles.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   RUN      | normal issue; branch / load-use / new memory wait resolved
//   MEM_WAIT | data memory busy, whole pipe frozen, wait_cnt counting
//   TRAP     | memory wait exceeded MEM_TIMEOUT, frozen until reset
//
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   id_*                  : decode-stage source registers and use flags
//   ex_rd, ex_mem_read    : EX destination / load flag
//   ex_branch_taken       : EX branch resolved taken
//   mem_req, mem_ready    : MEM-stage access request / completion
//   pc_we                 : PC write enable
//   stall_*               : 1 = pipeline register holds
//   flush_if_id/id_ex     : 1 = register loads a bubble
//   mem_timeout           : sticky trap flag
//   stall_count           : saturating count of cycles with pc_we = 0
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_BITS    = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_BITS-1:0]  id_rs1,
    input  logic [REG_BITS-1:0]  id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [REG_BITS-1:0]  ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    output logic                 pc_we,
    output logic                 stall_if_id,
    output logic                 stall_id_ex,
    output logic                 stall_ex_mem,
    output logic                 stall_mem_wb,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 mem_timeout,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hazard_state_t     state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              load_use;
    logic              mem_stall;

    load_use_detect #(
        .REG_BITS (REG_BITS)
    ) u_load_use_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .load_use    (load_use)
    );

    // Once waiting, mem_req no longer matters: the access is already in
    // flight and only mem_ready releases it.
    always_comb begin
        mem_stall = 1'b0;
        if (state == MEM_WAIT) begin
            mem_stall = !mem_ready;
        end else if (state == RUN) begin
            mem_stall = mem_req && !mem_ready;
        end
    end

    always_comb begin
        pc_we        = 1'b1;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        stall_mem_wb = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        if (reset) begin
            pc_we       = 1'b0;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (state == TRAP || mem_stall) begin
            pc_we        = 1'b0;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            stall_mem_wb = 1'b1;
        end else if (ex_branch_taken) begin
            // Redirect squashes the dependent instruction, so a coincident
            // load-use needs no stall.
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            pc_we       = 1'b0;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_count <= '0;
        end else begin
            if (!pc_we && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= WAIT_W'(1);
                    end
                end
                MEM_WAIT: begin
                    if (mem_stall) begin
                        wait_cnt <= wait_cnt + 1'b1;
                        if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                            state       <= TRAP;
                            mem_timeout <= 1'b1;
                        end
                    end else begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end
                end
                TRAP: begin
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share the
// stimulus: the default configuration and a 4-bit stall counter variant.
// Expected outputs come from a cycle-level model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs1, id_uses_rs2;
    logic       ex_mem_read, ex_branch_taken, mem_req, mem_ready;

    logic        pc_we, s_if, s_id, s_ex, s_mem, f_if, f_id, tmo;
    logic [15:0] cnt;
    logic        pc_we4, s_if4, s_id4, s_ex4, s_mem4, f_if4, f_id4, tmo4;
    logic [3:0]  cnt4;

    int checks = 0;
    int errors = 0;

    // reference model state
    int waits   = 0;    // consecutive stalled memory cycles so far
    bit trapped = 0;
    int stalls  = 0;    // unbounded stall-cycle count

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .stall_if_id(s_if), .stall_id_ex(s_id),
        .stall_ex_mem(s_ex), .stall_mem_wb(s_mem),
        .flush_if_id(f_if), .flush_id_ex(f_id),
        .mem_timeout(tmo), .stall_count(cnt)
    );

    pipeline_hazard_ctrl #(.CNT_WIDTH(4)) dut_c4 (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we4), .stall_if_id(s_if4), .stall_id_ex(s_id4),
        .stall_ex_mem(s_ex4), .stall_mem_wb(s_mem4),
        .flush_if_id(f_if4), .flush_id_ex(f_id4),
        .mem_timeout(tmo4), .stall_count(cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input int rs1, input int rs2, input bit u1, input bit u2,
                         input int rd, input bit ld, input bit br,
                         input bit mreq, input bit mrdy, input bit rst);
        id_rs1 = 3'(rs1); id_rs2 = 3'(rs2);
        id_uses_rs1 = u1; id_uses_rs2 = u2;
        ex_rd = 3'(rd); ex_mem_read = ld; ex_branch_taken = br;
        mem_req = mreq; mem_ready = mrdy; reset = rst;
    endtask

    task automatic idle(input bit rst);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, rst);
    endtask

    // One clock: check outputs against the model mid-cycle, then advance
    // the model across the rising edge.
    task automatic cycle();
        bit         lu, hold;
        logic [7:0] exp_v;
        int         small_cnt, big_cnt;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        hold = (waits == 0) ? (mem_req && !mem_ready) : !mem_ready;
        // {pc_we, stall x4, flush_if_id, flush_id_ex, mem_timeout}
        if (reset)                exp_v = {1'b0, 4'b0000, 2'b11, trapped};
        else if (trapped)         exp_v = 8'b0_1111_00_1;
        else if (hold)            exp_v = 8'b0_1111_00_0;
        else if (ex_branch_taken) exp_v = 8'b1_0000_11_0;
        else if (lu)              exp_v = 8'b0_1000_01_0;
        else                      exp_v = 8'b1_0000_00_0;
        small_cnt = (stalls > 15) ? 15 : stalls;
        big_cnt   = (stalls > 65535) ? 65535 : stalls;

        @(negedge clk);
        chk("ctrl", {24'd0, pc_we, s_if, s_id, s_ex, s_mem, f_if, f_id, tmo}, {24'd0, exp_v});
        chk("ctrl_c4", {24'd0, pc_we4, s_if4, s_id4, s_ex4, s_mem4, f_if4, f_id4, tmo4}, {24'd0, exp_v});
        chk("stall_count", {16'd0, cnt}, 32'(big_cnt));
        chk("stall_count_c4", {28'd0, cnt4}, 32'(small_cnt));

        @(posedge clk);
        if (reset) begin
            waits = 0; trapped = 0; stalls = 0;
        end else begin
            if (!exp_v[7]) stalls++;
            if (!trapped) begin
                if (hold) begin
                    waits++;
                    if (waits == MEM_TIMEOUT) trapped = 1;
                end else begin
                    waits = 0;
                end
            end
        end
        #1;
    endtask

    initial begin
        bit slow;
        int r1, r2;
        idle(1);
        @(posedge clk); #1;

        // reset held, then idle
        repeat (3) cycle();
        idle(0);
        cycle();
        chk("post_reset_cnt", {16'd0, cnt}, 32'd0);

        // load-use on rs2
        drive(0, 3, 0, 1, 3, 1, 0, 0, 1, 0); cycle();
        idle(0); cycle();
        chk("lu_cnt", {16'd0, cnt}, 32'd1);
        // load into r0: no hazard
        drive(0, 0, 0, 1, 0, 1, 0, 0, 1, 0); cycle();
        // load-use coinciding with a taken branch
        drive(0, 3, 0, 1, 3, 1, 1, 0, 1, 0); cycle();
        idle(0); cycle();
        chk("lu_r0_br_cnt", {16'd0, cnt}, 32'd1);

        // 4-cycle memory wait then release
        repeat (4) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle(); end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); cycle();
        idle(0); cycle();
        chk("memwait_cnt", {16'd0, cnt}, 32'd5);

        // timeout trap, saturation of the narrow counter
        idle(1); cycle();
        repeat (20) begin drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); cycle(); end
        chk("trap_flag", {31'd0, tmo}, 32'd1);
        chk("trap_cnt", {16'd0, cnt}, 32'd20);
        chk("trap_cnt_c4", {28'd0, cnt4}, 32'd15);
        repeat (3) begin drive(0, 0, 0, 0, 0, 0, 1, 1, 1, 0); cycle(); end
        chk("trap_sticky", {31'd0, tmo}, 32'd1);
        idle(1); cycle();
        chk("trap_cleared", {31'd0, tmo}, 32'd0);
        idle(0); cycle();

        // randomized traffic
        slow = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) slow = ~slow;
            r1 = $urandom_range(0, 7);
            r2 = $urandom_range(0, 7);
            drive(r1, r2,
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0) ? r1 :
                  ($urandom_range(0, 2) == 0) ? r2 : $urandom_range(0, 7),
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 9) < 2,
                  $urandom_range(0, 9) < 3,
                  slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 6),
                  $urandom_range(0, 149) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
